// File: rtl/tinyml_cam_awb_pkg.sv
// Shared types, gain constants and helpers for the camera auto-white-balance controller.
package tinyml_cam_awb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EVAL   = 2'd2,
    ST_UPDATE = 2'd3
  } awb_state_e;

  localparam logic [2:0] GAIN_UNITY = 3'd4;
  localparam logic [2:0] GAIN_MIN   = 3'd1;
  localparam logic [2:0] GAIN_MAX   = 3'd7;

  // Accumulator width: a full frame of one channel-pair plus one bit for the doubled green count.
  function automatic int acc_w(input int p_depth, input int width, input int height);
    return p_depth + $clog2(width * height / 4) + 1;
  endfunction

  // One gain step toward green, always landing inside [GAIN_MIN, GAIN_MAX].
  function automatic logic [2:0] step_gain(input logic [2:0] code, input logic dec, input logic inc);
    logic [2:0] res;
    if (dec) begin
      res = (code > GAIN_MIN) ? code - 3'd1 : GAIN_MIN;
    end else if (inc) begin
      res = (code < GAIN_MAX) ? code + 3'd1 : GAIN_MAX;
    end else begin
      res = (code < GAIN_MIN) ? GAIN_MIN : code;
    end
    return res;
  endfunction

endpackage

// File: rtl/tinyml_cam_awb_stats.sv
// Per-frame Bayer statistics: line parity, beat/line counters and R/G/B accumulators.
module tinyml_cam_awb_stats
  import tinyml_cam_awb_pkg::*;
#(
  parameter int P_DEPTH      = 10,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ACC_W        = acc_w(P_DEPTH, FRAME_WIDTH, FRAME_HEIGHT),
  parameter int LINE_W       = $clog2(FRAME_HEIGHT + 1) + 1
) (
  input  logic                   i_pclk,
  input  logic                   i_arst,
  input  logic                   i_clear,
  input  logic                   i_beat_en,
  input  logic [4*P_DEPTH-1:0]   i_data,
  output logic [ACC_W-1:0]       o_r_sum,
  output logic [ACC_W-1:0]       o_g_sum,
  output logic [ACC_W-1:0]       o_b_sum,
  output logic [LINE_W-1:0]      o_line_cnt,
  output logic                   o_partial
);

  localparam int BEATS  = FRAME_WIDTH / 4;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  logic [ACC_W-1:0]  r_sum_r, g_sum_r, b_sum_r;
  logic [ACC_W-1:0]  r_sum_s, g_sum_s, b_sum_s;
  logic [ACC_W-1:0]  r_base_s, g_base_s, b_base_s;
  logic [ACC_W-1:0]  pair_even_s, pair_odd_s;
  logic [BEAT_W-1:0] beat_r, beat_s, beat_base_s;
  logic [LINE_W-1:0] line_r, line_s, line_base_s;
  logic              par_r, par_s, par_base_s;

  // Even columns (pix0/pix2) are R or G, odd columns (pix1/pix3) are G or B depending on parity.
  assign pair_even_s = ACC_W'(i_data[P_DEPTH-1:0])         + ACC_W'(i_data[3*P_DEPTH-1:2*P_DEPTH]);
  assign pair_odd_s  = ACC_W'(i_data[2*P_DEPTH-1:P_DEPTH]) + ACC_W'(i_data[4*P_DEPTH-1:3*P_DEPTH]);

  // Next-state for counters and sums; a clear coinciding with a beat restarts from that beat.
  always_comb begin
    r_base_s    = i_clear ? '0 : r_sum_r;
    g_base_s    = i_clear ? '0 : g_sum_r;
    b_base_s    = i_clear ? '0 : b_sum_r;
    beat_base_s = i_clear ? '0 : beat_r;
    line_base_s = i_clear ? '0 : line_r;
    par_base_s  = i_clear ? 1'b0 : par_r;
    r_sum_s = r_base_s;
    g_sum_s = g_base_s;
    b_sum_s = b_base_s;
    beat_s  = beat_base_s;
    line_s  = line_base_s;
    par_s   = par_base_s;
    if (i_beat_en) begin
      if (!par_base_s) begin
        r_sum_s = r_base_s + pair_even_s;
        g_sum_s = g_base_s + pair_odd_s;
      end else begin
        b_sum_s = b_base_s + pair_odd_s;
        g_sum_s = g_base_s + pair_even_s;
      end
      if (beat_base_s == BEAT_LAST) begin
        beat_s = '0;
        par_s  = ~par_base_s;
        // Saturate so an over-long frame can never wrap back to a valid count.
        line_s = (line_base_s == {LINE_W{1'b1}}) ? line_base_s : line_base_s + LINE_W'(1);
      end else begin
        beat_s = beat_base_s + BEAT_W'(1);
      end
    end else begin
      beat_s = beat_base_s;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      r_sum_r <= '0;
      g_sum_r <= '0;
      b_sum_r <= '0;
      beat_r  <= '0;
      line_r  <= '0;
      par_r   <= 1'b0;
    end else begin
      r_sum_r <= r_sum_s;
      g_sum_r <= g_sum_s;
      b_sum_r <= b_sum_s;
      beat_r  <= beat_s;
      line_r  <= line_s;
      par_r   <= par_s;
    end
  end

  assign o_r_sum    = r_sum_r;
  assign o_g_sum    = g_sum_r;
  assign o_b_sum    = b_sum_r;
  assign o_line_cnt = line_r;
  assign o_partial  = (beat_r != '0);

endmodule

// File: rtl/tinyml_cam_awb_ctrl.sv
// Closed-loop auto-white-balance controller: frame FSM, deadband comparators and gain registers.
// Optional manual override ports are enabled by defining TINYML_AWB_MANUAL_EN.
module tinyml_cam_awb_ctrl
  import tinyml_cam_awb_pkg::*;
#(
  parameter int P_DEPTH        = 10,
  parameter int PW             = P_DEPTH * 4,
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int DEADBAND_SHIFT = 4,
  parameter int UPDATE_FRAMES  = 2
) (
  input  logic          i_pclk,
  input  logic          i_arst,
  input  logic          i_vs,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  input  logic          i_awb_en,
  input  logic [2:0]    i_green_gain,
`ifdef TINYML_AWB_MANUAL_EN
  input  logic          i_manual,
  input  logic [2:0]    i_manual_red_gain,
  input  logic [2:0]    i_manual_green_gain,
  input  logic [2:0]    i_manual_blue_gain,
`endif
  output logic [2:0]    o_red_gain,
  output logic [2:0]    o_green_gain,
  output logic [2:0]    o_blue_gain,
  output logic          o_update,
  output logic          o_frame_drop
);

  localparam int ACC_W  = acc_w(P_DEPTH, FRAME_WIDTH, FRAME_HEIGHT);
  localparam int LINE_W = $clog2(FRAME_HEIGHT + 1) + 1;
  localparam int FCNT_W = $clog2(UPDATE_FRAMES + 1);

  awb_state_e        state_r, state_s;
  logic              vs_d_r, vs_fall_s, vs_rise_s;
  logic              clear_s, beat_en_s, frame_ok_s, drop_s, upd_s;
  logic [FCNT_W-1:0] fcnt_r, fcnt_s;
  logic [FCNT_W:0]   fcnt_inc_s;
  logic [ACC_W-1:0]  r_sum_s, g_sum_s, b_sum_s, g_ref_s, tol_s, thr_lo_s;
  logic [ACC_W:0]    thr_hi_s;
  logic [LINE_W-1:0] line_cnt_s;
  logic              partial_s;
  logic [2:0]        red_r, green_r, blue_r, red_s, green_s, blue_s;
  logic              upd_r, drop_r;
  logic              manual_s;
  logic [2:0]        man_red_s, man_green_s, man_blue_s;

`ifdef TINYML_AWB_MANUAL_EN
  assign manual_s    = i_manual;
  assign man_red_s   = i_manual_red_gain;
  assign man_green_s = i_manual_green_gain;
  assign man_blue_s  = i_manual_blue_gain;
`else
  assign manual_s    = 1'b0;
  assign man_red_s   = GAIN_UNITY;
  assign man_green_s = GAIN_UNITY;
  assign man_blue_s  = GAIN_UNITY;
`endif

  assign vs_fall_s  = vs_d_r & ~i_vs;
  assign vs_rise_s  = ~vs_d_r & i_vs;
  assign clear_s    = vs_fall_s & ((state_r == ST_IDLE) | (state_r == ST_ACCUM));
  assign beat_en_s  = i_valid & ~i_vs & ((state_r == ST_ACCUM) | clear_s);
  assign frame_ok_s = (line_cnt_s == LINE_W'(FRAME_HEIGHT)) & ~partial_s;
  assign fcnt_inc_s = {1'b0, fcnt_r} + (FCNT_W + 1)'(1);

  tinyml_cam_awb_stats #(
    .P_DEPTH      (P_DEPTH),
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .ACC_W        (ACC_W),
    .LINE_W       (LINE_W)
  ) u_stats (
    .i_pclk     (i_pclk),
    .i_arst     (i_arst),
    .i_clear    (clear_s),
    .i_beat_en  (beat_en_s),
    .i_data     (i_data),
    .o_r_sum    (r_sum_s),
    .o_g_sum    (g_sum_s),
    .o_b_sum    (b_sum_s),
    .o_line_cnt (line_cnt_s),
    .o_partial  (partial_s)
  );

  // Green sum holds twice as many pixels as R or B, so halve it before comparing.
  assign g_ref_s  = g_sum_s >> 1;
  assign tol_s    = g_ref_s >> DEADBAND_SHIFT;
  assign thr_hi_s = {1'b0, g_ref_s} + {1'b0, tol_s};
  assign thr_lo_s = g_ref_s - tol_s;

  // Frame FSM next-state, frame counter and drop decision.
  always_comb begin
    state_s = state_r;
    fcnt_s  = fcnt_r;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vs_fall_s) state_s = ST_ACCUM;
        else           state_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (vs_fall_s)      state_s = ST_ACCUM;
        else if (vs_rise_s) state_s = ST_EVAL;
        else                state_s = ST_ACCUM;
      end
      ST_EVAL: begin
        if (!frame_ok_s) begin
          drop_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (fcnt_inc_s >= (FCNT_W + 1)'(UPDATE_FRAMES)) begin
          fcnt_s  = fcnt_inc_s[FCNT_W-1:0];
          state_s = ST_UPDATE;
        end else begin
          fcnt_s  = fcnt_inc_s[FCNT_W-1:0];
          state_s = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        fcnt_s  = '0;
        state_s = ST_IDLE;
      end
      default: begin
        fcnt_s  = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Gain next-values: manual override wins, otherwise step only in UPDATE with the loop enabled.
  always_comb begin
    red_s   = red_r;
    green_s = green_r;
    blue_s  = blue_r;
    upd_s   = 1'b0;
    if (manual_s) begin
      red_s   = man_red_s;
      green_s = man_green_s;
      blue_s  = man_blue_s;
    end else if ((state_r == ST_UPDATE) && i_awb_en) begin
      red_s   = step_gain(red_r, {1'b0, r_sum_s} > thr_hi_s, r_sum_s < thr_lo_s);
      blue_s  = step_gain(blue_r, {1'b0, b_sum_s} > thr_hi_s, b_sum_s < thr_lo_s);
      green_s = i_green_gain;
      upd_s   = 1'b1;
    end else begin
      upd_s   = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= ST_IDLE;
      vs_d_r  <= 1'b0;
      fcnt_r  <= '0;
      red_r   <= GAIN_UNITY;
      green_r <= GAIN_UNITY;
      blue_r  <= GAIN_UNITY;
      upd_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      vs_d_r  <= i_vs;
      fcnt_r  <= fcnt_s;
      red_r   <= red_s;
      green_r <= green_s;
      blue_r  <= blue_s;
      upd_r   <= upd_s;
      drop_r  <= drop_s;
    end
  end

  assign o_red_gain   = red_r;
  assign o_green_gain = green_r;
  assign o_blue_gain  = blue_r;
  assign o_update     = upd_r;
  assign o_frame_drop = drop_r;

endmodule

// File: tb/tb_tinyml_cam_awb_ctrl.sv
// Randomized self-checking bench: two controllers (update every 2 frames / every frame) share one stream.
module tb_tinyml_cam_awb_ctrl;

  localparam int PD  = 10;
  localparam int FW  = 16;
  localparam int FH  = 8;
  localparam int BPL = FW / 4;
  localparam int DS  = 4;

  logic          i_pclk = 1'b0;
  logic          i_arst, i_vs, i_valid, i_awb_en;
  logic [4*PD-1:0] i_data;
  logic [2:0]    i_green_gain;
  logic [2:0]    red_o [2];
  logic [2:0]    green_o [2];
  logic [2:0]    blue_o [2];
  logic          upd_o [2];
  logic          drop_o [2];
`ifdef TINYML_AWB_MANUAL_EN
  logic          i_manual;
  logic [2:0]    i_manual_red_gain, i_manual_green_gain, i_manual_blue_gain;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state per instance
  int uf [2] = '{2, 1};
  int m_red [2], m_green [2], m_blue [2], m_cnt [2];
  int exp_upd [2], exp_drop [2];
  bit m_manual = 1'b0;

  always #5 i_pclk = ~i_pclk;

  tinyml_cam_awb_ctrl #(.P_DEPTH(PD), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                        .DEADBAND_SHIFT(DS), .UPDATE_FRAMES(2)) u_dut0 (
    .i_pclk(i_pclk), .i_arst(i_arst), .i_vs(i_vs), .i_valid(i_valid), .i_data(i_data),
    .i_awb_en(i_awb_en), .i_green_gain(i_green_gain),
`ifdef TINYML_AWB_MANUAL_EN
    .i_manual(i_manual), .i_manual_red_gain(i_manual_red_gain),
    .i_manual_green_gain(i_manual_green_gain), .i_manual_blue_gain(i_manual_blue_gain),
`endif
    .o_red_gain(red_o[0]), .o_green_gain(green_o[0]), .o_blue_gain(blue_o[0]),
    .o_update(upd_o[0]), .o_frame_drop(drop_o[0]));

  tinyml_cam_awb_ctrl #(.P_DEPTH(PD), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                        .DEADBAND_SHIFT(DS), .UPDATE_FRAMES(1)) u_dut1 (
    .i_pclk(i_pclk), .i_arst(i_arst), .i_vs(i_vs), .i_valid(i_valid), .i_data(i_data),
    .i_awb_en(i_awb_en), .i_green_gain(i_green_gain),
`ifdef TINYML_AWB_MANUAL_EN
    .i_manual(i_manual), .i_manual_red_gain(i_manual_red_gain),
    .i_manual_green_gain(i_manual_green_gain), .i_manual_blue_gain(i_manual_blue_gain),
`endif
    .o_red_gain(red_o[1]), .o_green_gain(green_o[1]), .o_blue_gain(blue_o[1]),
    .o_update(upd_o[1]), .o_frame_drop(drop_o[1]));

  function automatic int clamp_gain(input int g);
    return (g < 1) ? 1 : ((g > 7) ? 7 : g);
  endfunction

  function automatic int pixval(input int base, input int jit);
    int v;
    v = base;
    if (jit > 0) v = base + int'($urandom_range(0, 2 * jit)) - jit;
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Frame-level reference: average-per-channel comparison against half the green total.
  task automatic model_frame(input bit ok, input longint rs, input longint gs, input longint bs, input int gg);
    longint gref, tol;
    gref = gs / 2;
    tol  = gref / (1 << DS);
    for (int k = 0; k < 2; k++) begin
      exp_upd[k]  = 0;
      exp_drop[k] = 0;
      if (!ok) begin
        exp_drop[k] = 1;
      end else begin
        m_cnt[k]++;
        if (m_cnt[k] >= uf[k]) begin
          m_cnt[k] = 0;
          if (i_awb_en && !m_manual) begin
            if (rs > gref + tol)      m_red[k] = clamp_gain(m_red[k] - 1);
            else if (rs < gref - tol) m_red[k] = clamp_gain(m_red[k] + 1);
            else                      m_red[k] = clamp_gain(m_red[k]);
            if (bs > gref + tol)      m_blue[k] = clamp_gain(m_blue[k] - 1);
            else if (bs < gref - tol) m_blue[k] = clamp_gain(m_blue[k] + 1);
            else                      m_blue[k] = clamp_gain(m_blue[k]);
            m_green[k] = gg;
            exp_upd[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_gains(input string tag);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({red_o[k], green_o[k], blue_o[k]} !== {3'(m_red[k]), 3'(m_green[k]), 3'(m_blue[k])}) begin
        n_fail++;
        $display("FAIL gains[%0d] %s: got r/g/b=%0d/%0d/%0d expected %0d/%0d/%0d", k, tag,
                 red_o[k], green_o[k], blue_o[k], m_red[k], m_green[k], m_blue[k]);
      end
    end
  endtask

  // Sends one frame; rst_rel >= 0 releases reset at that beat and leaves the frame unmodelled.
  task automatic send_frame(input int lines, input int extra, input int rv, input int gv, input int bv,
                            input int jit, input int rst_rel, input string tag);
    longint rs, gs, bs;
    int y, col, v, total;
    int up_n [2], up_at [2], dr_n [2], dr_at [2];
    rs = 0; gs = 0; bs = 0;
    total = lines * BPL + extra;
    @(negedge i_pclk);
    i_vs = 1'b0;
    for (int n = 0; n < total; n++) begin
      if (n == rst_rel) i_arst = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        i_data  = (4*PD)'({$urandom(), $urandom()});
        @(negedge i_pclk);
      end
      y = n / BPL;
      for (int k = 0; k < 4; k++) begin
        col = (n % BPL) * 4 + k;
        if ((y % 2) == 0) begin
          if ((col % 2) == 0) begin v = pixval(rv, jit); rs += v; end
          else                begin v = pixval(gv, jit); gs += v; end
        end else begin
          if ((col % 2) == 0) begin v = pixval(gv, jit); gs += v; end
          else                begin v = pixval(bv, jit); bs += v; end
        end
        i_data[k*PD +: PD] = PD'(v);
      end
      i_valid = 1'b1;
      @(negedge i_pclk);
    end
    i_valid = 1'b0;
    i_vs    = 1'b1;
    if (rst_rel < 0) begin
      model_frame(lines == FH && extra == 0, rs, gs, bs, int'(i_green_gain));
    end else begin
      exp_upd  = '{0, 0};
      exp_drop = '{0, 0};
    end
    for (int k = 0; k < 2; k++) begin
      up_n[k] = 0; up_at[k] = 0; dr_n[k] = 0; dr_at[k] = 0;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge i_pclk);
      for (int k = 0; k < 2; k++) begin
        if (upd_o[k])  begin up_n[k]++; up_at[k] = i; end
        if (drop_o[k]) begin dr_n[k]++; dr_at[k] = i; end
      end
      i_valid = 1'($urandom_range(0, 1));
      i_data  = (4*PD)'({$urandom(), $urandom()});
    end
    i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (up_n[k] != exp_upd[k] || (exp_upd[k] == 1 && up_at[k] != 3)) begin
        n_fail++;
        $display("FAIL update[%0d] %s: got count=%0d at cycle %0d, expected count=%0d at cycle 3",
                 k, tag, up_n[k], up_at[k], exp_upd[k]);
      end
      n_tests++;
      if (dr_n[k] != exp_drop[k] || (exp_drop[k] == 1 && dr_at[k] != 2)) begin
        n_fail++;
        $display("FAIL drop[%0d] %s: got count=%0d at cycle %0d, expected count=%0d at cycle 2",
                 k, tag, dr_n[k], dr_at[k], exp_drop[k]);
      end
    end
    check_gains(tag);
  endtask

  task automatic do_reset();
    i_arst = 1'b1;
    i_vs   = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_red[k] = 4; m_green[k] = 4; m_blue[k] = 4; m_cnt[k] = 0;
    end
    repeat (3) @(negedge i_pclk);
    i_arst = 1'b0;
    @(negedge i_pclk);
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    repeat (2) @(negedge i_pclk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({red_o[k], green_o[k], blue_o[k], upd_o[k], drop_o[k]} !== {3'd4, 3'd4, 3'd4, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got r/g/b=%0d/%0d/%0d upd=%0b drop=%0b expected 4/4/4 0 0",
                 k, red_o[k], green_o[k], blue_o[k], upd_o[k], drop_o[k]);
      end
    end
    do_reset();
    check_gains("after_reset");
  endtask

  task automatic test_uniform();
    do_reset();
    i_green_gain = 3'd4;
    send_frame(FH, 0, 512, 512, 512, 0, -1, "uniform_f1");
    send_frame(FH, 0, 512, 512, 512, 0, -1, "uniform_f2");
  endtask

  task automatic test_offset();
    do_reset();
    send_frame(FH, 0, 600, 512, 400, 0, -1, "offset");
  endtask

  task automatic test_clamp();
    do_reset();
    for (int f = 0; f < 8; f++) send_frame(FH, 0, 1023, 512, 512, 0, -1, "clamp");
  endtask

  task automatic test_drop();
    send_frame(FH - 1, 0, 700, 512, 300, 0, -1, "short_frame");
    send_frame(FH, 2, 700, 512, 300, 0, -1, "partial_line");
    send_frame(FH, 0, 700, 512, 300, 0, -1, "after_drop");
  endtask

  task automatic test_midframe_reset();
    i_arst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_red[k] = 4; m_green[k] = 4; m_blue[k] = 4; m_cnt[k] = 0;
    end
    send_frame(FH, 0, 900, 512, 200, 0, 9, "midframe_partial");
    send_frame(FH, 0, 900, 512, 200, 0, -1, "midframe_next");
  endtask

  task automatic test_awb_disable();
    i_awb_en = 1'b0;
    i_green_gain = 3'd6;
    for (int f = 0; f < 3; f++) send_frame(FH, 0, 300, 512, 800, 0, -1, "awb_off");
    i_awb_en = 1'b1;
    for (int f = 0; f < 2; f++) send_frame(FH, 0, 300, 512, 800, 0, -1, "awb_on");
  endtask

  task automatic test_random();
    int lines, extra;
    for (int f = 0; f < 14; f++) begin
      lines = FH;
      extra = 0;
      if ($urandom_range(0, 5) == 0) lines = FH - int'($urandom_range(1, 2));
      if ($urandom_range(0, 7) == 0) extra = int'($urandom_range(1, BPL - 1));
      i_green_gain = 3'($urandom_range(0, 7));
      send_frame(lines, extra, int'($urandom_range(100, 900)), int'($urandom_range(300, 700)),
                 int'($urandom_range(100, 900)), int'($urandom_range(0, 40)), -1, "random");
    end
  endtask

`ifdef TINYML_AWB_MANUAL_EN
  task automatic test_manual();
    @(negedge i_pclk);
    i_manual = 1'b1;
    i_manual_red_gain = 3'd2; i_manual_green_gain = 3'd5; i_manual_blue_gain = 3'd7;
    m_manual = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_red[k] = 2; m_green[k] = 5; m_blue[k] = 7;
    end
    @(negedge i_pclk);
    check_gains("manual_next_cycle");
    send_frame(FH, 0, 900, 512, 100, 0, -1, "manual_frame");
    i_manual = 1'b0;
    m_manual = 1'b0;
    send_frame(FH, 0, 900, 512, 100, 0, -1, "manual_release");
    send_frame(FH, 0, 900, 512, 100, 0, -1, "manual_release");
  endtask
`endif

  initial begin
    i_arst = 1'b1; i_vs = 1'b1; i_valid = 1'b0; i_data = '0;
    i_awb_en = 1'b1; i_green_gain = 3'd4;
`ifdef TINYML_AWB_MANUAL_EN
    i_manual = 1'b0; i_manual_red_gain = 3'd4; i_manual_green_gain = 3'd4; i_manual_blue_gain = 3'd4;
`endif
    test_reset();
    test_uniform();
    test_offset();
    test_clamp();
    test_drop();
    test_midframe_reset();
    test_awb_disable();
    test_random();
`ifdef TINYML_AWB_MANUAL_EN
    test_manual();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
